// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    W_LO,
    W_HI,
    CHK,
    FINISH,
    FAIL
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned BYTES_PER_WORD = 2;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampler, glitch rejection on the start bit.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FERR
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF  = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);

  rx_state_e        state, state_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [2:0]       bit_idx, bit_idx_d;
  logic [7:0]       shift, shift_d, data_d;
  logic             valid_d, ferr_d;
  logic             half_tick_c, full_tick_c;

  assign half_tick_c = (cnt == HALF_LAST);
  assign full_tick_c = (cnt == FULL_LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (rx_prev && !rx_sync) state_next = RX_START;
      RX_START: if (half_tick_c) state_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (full_tick_c && bit_idx == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (full_tick_c) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Counter restarts at each sample point so data bits land mid-bit.
  always_comb begin
    cnt_d     = cnt + CNT_W'(1);
    bit_idx_d = bit_idx;
    shift_d   = shift;
    data_d    = DATA;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      RX_START: if (half_tick_c) cnt_d = '0;
      RX_DATA: if (full_tick_c) begin
        cnt_d     = '0;
        shift_d   = {rx_sync, shift[7:1]};
        bit_idx_d = bit_idx + 3'd1;
      end
      RX_STOP: if (full_tick_c) begin
        cnt_d = '0;
        if (rx_sync) begin
          valid_d = 1'b1;
          data_d  = shift;
        end else begin
          ferr_d = 1'b1;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      DATA    <= '0;
      VALID   <= 1'b0;
      FERR    <= 1'b0;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
      DATA    <= data_d;
      VALID   <= valid_d;
      FERR    <= ferr_d;
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Boot loader: receives a word-count-prefixed image over UART and writes it to RAM from address 0.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_ram_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UART_RX,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_DATA,
  output logic              RAM_WREN,
  output logic              CORE_RST,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned CPB       = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_LAST = CHK;
`else
  localparam loader_state_e AFTER_LAST = FINISH;
`endif

  loader_state_e     state, state_next;
  logic [7:0]        rx_data;
  logic              rx_valid, rx_ferr;
  logic [7:0]        n_lo, n_lo_d, lo_byte, lo_byte_d;
  logic [CNT_W-1:0]  n_words, n_words_d, word_cnt, word_cnt_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_data_d;
  logic              ram_wren_d, core_rst_d, done_d, err_d;
  logic [15:0]       hdr_n_c;
  logic              hdr_too_big_c, last_word_c;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum, csum_d;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) u_rx (
    .CLK   (CLK),
    .RST   (RST),
    .RX    (UART_RX),
    .DATA  (rx_data),
    .VALID (rx_valid),
    .FERR  (rx_ferr)
  );

  assign hdr_n_c       = {rx_data, n_lo};
  assign hdr_too_big_c = 32'(hdr_n_c) > MAX_WORDS;
  assign last_word_c   = (word_cnt + CNT_W'(1)) == n_words;

  always_ff @(posedge CLK) begin
    if (RST) state <= HDR_LO;
    else     state <= state_next;
  end

  // W_HI stays put for the write cycle; the advance happens while RAM_WREN is high.
  always_comb begin
    state_next = state;
    if (rx_ferr && state != FINISH && state != FAIL) begin
      state_next = FAIL;
    end else begin
      case (state)
        HDR_LO: if (rx_valid) state_next = HDR_HI;
        HDR_HI: if (rx_valid) begin
          if (hdr_n_c == 16'd0)  state_next = AFTER_LAST;
          else if (hdr_too_big_c) state_next = FAIL;
          else                    state_next = W_LO;
        end
        W_LO:   if (rx_valid) state_next = W_HI;
        W_HI:   if (RAM_WREN) state_next = last_word_c ? AFTER_LAST : W_LO;
`ifdef LOADER_CHECKSUM_EN
        CHK:    if (rx_valid) state_next = (rx_data == csum) ? FINISH : FAIL;
`endif
        FINISH: state_next = FINISH;
        FAIL:   state_next = FAIL;
        default: state_next = FAIL;
      endcase
    end
  end

  always_comb begin
    n_lo_d     = n_lo;
    n_words_d  = n_words;
    lo_byte_d  = lo_byte;
    word_cnt_d = word_cnt;
    ram_addr_d = RAM_ADDR;
    ram_data_d = RAM_DATA;
    ram_wren_d = 1'b0;
    core_rst_d = CORE_RST;
    done_d     = DONE;
    err_d      = ERR;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum;
`endif
    case (state)
      HDR_LO: if (rx_valid) n_lo_d = rx_data;
      HDR_HI: if (rx_valid) n_words_d = CNT_W'(hdr_n_c);
      W_LO: if (rx_valid) begin
        lo_byte_d = rx_data;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum ^ rx_data;
`endif
      end
      W_HI: begin
        if (rx_valid && !RAM_WREN && state_next == W_HI) begin
          ram_wren_d = 1'b1;
          ram_data_d = DATA_W'({rx_data, lo_byte});
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum ^ rx_data;
`endif
        end
        if (RAM_WREN) begin
          word_cnt_d = word_cnt + CNT_W'(1);
          if (!(&RAM_ADDR)) ram_addr_d = RAM_ADDR + ADDR_W'(1);
        end
      end
      default: ;
    endcase
    if (state_next == FINISH) begin
      ram_addr_d = '0;
      done_d     = 1'b1;
      core_rst_d = 1'b0;
    end
    if (state_next == FAIL) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      n_lo     <= '0;
      n_words  <= '0;
      lo_byte  <= '0;
      word_cnt <= '0;
      RAM_ADDR <= '0;
      RAM_DATA <= '0;
      RAM_WREN <= 1'b0;
      CORE_RST <= 1'b1;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      n_lo     <= n_lo_d;
      n_words  <= n_words_d;
      lo_byte  <= lo_byte_d;
      word_cnt <= word_cnt_d;
      RAM_ADDR <= ram_addr_d;
      RAM_DATA <= ram_data_d;
      RAM_WREN <= ram_wren_d;
      CORE_RST <= core_rst_d;
      DONE     <= done_d;
      ERR      <= err_d;
`ifdef LOADER_CHECKSUM_EN
      csum     <= csum_d;
`endif
    end
  end

endmodule

// File: doc/uart_ram_loader.md
Name: uart_ram_loader

Overview:
Boot-time program loader placed upstream of the shared 4K x 16 program/data RAM. It receives a program image over a UART RX line and writes it word by word into RAM starting at address 0. It holds the core in reset until the image is complete. At top level, the RAM address, data and write-enable are taken from the loader while CORE_RST=1 and from the core otherwise.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz.
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division).
ADDR_W, 12, RAM address width.
DATA_W, 16, RAM word width; fixed at 2 bytes per word.

Ports:
CLK  in  1  system clock; all logic on the rising edge.
RST  in  1  reset, synchronous, active-high.
UART_RX  in  1  asynchronous serial input, idle high, 8N1, LSB first.
RAM_ADDR  out  ADDR_W  write address.
RAM_DATA  out  DATA_W  write data.
RAM_WREN  out  1  one-cycle write strobe.
CORE_RST  out  1  hold the core in reset while high.
DONE  out  1  image loaded successfully; sticky until RST.
ERR  out  1  load aborted; sticky until RST.

Behaviour:
- Reset values: RAM_ADDR=0, RAM_DATA=0, RAM_WREN=0, CORE_RST=1, DONE=0, ERR=0. The FSM enters HDR_LO and the RX datapath returns to idle.
- RST asserted mid-load discards all progress. Words already written to RAM are not cleared.
- RX path:
  - UART_RX passes through a 2-FF synchronizer before any use.
  - A falling edge in idle starts a bit counter. The line is re-sampled at CLKS_PER_BIT/2; if it is high, the event is a glitch and the path returns to idle.
  - Data bits are sampled every CLKS_PER_BIT after that, LSB first, then the stop bit.
  - Stop bit = 1 produces a one-cycle byte_valid pulse with the byte.
  - Stop bit = 0 is a framing error: the FSM goes to FAIL.
- Protocol, all fields little-endian:
  - 2-byte word count N.
  - Then 2N bytes: low byte of each word first.
  - Then, only with the optional feature enabled, 1 checksum byte.
- FSM states and transitions:
  - HDR_LO: latch the low byte of N, go to HDR_HI.
  - HDR_HI: latch the high byte of N.
    - N=0: go to FINISH.
    - N > 2^ADDR_W: go to FAIL, with no writes.
    - Otherwise go to W_LO.
  - W_LO: latch the low byte, go to W_HI.
  - W_HI: on the byte, drive RAM_DATA={hi,lo} and RAM_WREN=1 for exactly one cycle, with RAM_ADDR holding the current address. On the following cycle, increment RAM_ADDR and the written-word count. If the count equals N, go to FINISH (or CHK when the feature is enabled); otherwise go to W_LO.
  - FINISH: DONE=1, CORE_RST=0, RAM_ADDR returns to 0. Stay in FINISH; further RX bytes are ignored.
  - FAIL: ERR=1, CORE_RST stays 1. Stay in FAIL until RST.
- RAM_ADDR never wraps. N=4096 writes addresses 0..4095 and the counter stops there.
- RAM_WREN is never asserted outside W_HI and never for two consecutive cycles.
- Latency: RAM_WREN rises 1 cycle after byte_valid of the high byte. DONE rises 1 cycle after the last write (no checksum) or 1 cycle after the checksum byte.

Optional Feature:
LOADER_CHECKSUM_EN.
- Defined: state CHK follows the last word. It expects one byte equal to the XOR of all 2N data bytes (header bytes are excluded; N=0 expects 0x00). A match goes to FINISH; a mismatch goes to FAIL.
- Undefined: CHK and the XOR accumulator are absent, and the last word goes directly to FINISH.

Decomposition:
- Package loader_pkg contains:
  - the FSM state encoding: HDR_LO, HDR_HI, W_LO, W_HI, CHK, FINISH, FAIL;
  - the CLKS_PER_BIT function;
  - the BYTES_PER_WORD=2 constant.
- One sub-module, uart_rx: synchronizer plus bit sampler. Ports: CLK, RST, RX, DATA[7:0], VALID, FERR.

Test Plan:
- N=0x0003, words 0x1234, 0xABCD, 0x0001 at 115200 baud -> writes (0,0x1234), (1,0xABCD), (2,0x0001), each WREN one cycle wide; DONE=1 and CORE_RST=0 after the third write.
- Header 0x00,0x00 -> no WREN; DONE=1. With LOADER_CHECKSUM_EN, DONE follows checksum 0x00, and checksum 0x01 gives ERR=1.
- N=0x1001 -> ERR=1, zero writes, CORE_RST stays 1. N=0x1000 with random data -> last write at address 0xFFF, then DONE.
- Stop bit forced low on the 3rd byte -> ERR=1, no further writes even as more bytes arrive.
- A 0.3-bit-wide low glitch on UART_RX while idle -> no byte accepted; a following valid frame 0x5A decodes correctly.
- RST pulsed for 1 cycle after 2 of 3 words -> outputs return to reset values; a fresh full image then loads to DONE with writes restarting at address 0.
